// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, owner and request types for the memory port arbiter
package mem_arb_pkg;
  localparam int MEMARB_AW = 32;
  localparam int MEMARB_DW = 32;
  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D, WAIT_DROP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  typedef struct packed {
    logic [MEMARB_AW-1:0] addr;
    logic                 wen;
    logic [MEMARB_DW-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/arb_starve_picker.sv
// arb_starve_picker: data-first grant with a bounded run of data grants while a fetch waits
module arb_starve_picker import mem_arb_pkg::*; #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   i_valid,
  input  logic   d_valid,
  input  logic   issue,
  input  logic   i_fire,
  input  logic   d_fire,
  output owner_t owner
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] cnt;
  logic at_limit;
  assign at_limit = cnt == CW'(STARVE_LIMIT);
  assign owner = (issue && d_valid && !(i_valid && at_limit)) ? OWN_D : OWN_I;
  // count data grants made while a fetch is waiting; a fetch grant or an idle fetch side ends the run
  always_ff @(posedge clk)
    if (!reset_n || i_fire || !i_valid) cnt <= '0;
    else if (d_fire && !at_limit) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store; MEMARB_PERF_EN adds perf counters
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_WIDTH   = MEMARB_AW,
  parameter int DATA_WIDTH   = MEMARB_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic                  i_kill,
  output logic                  i_resp_valid,
  output logic [ADDR_WIDTH-1:0] i_resp_addr,
  output logic [DATA_WIDTH-1:0] i_resp_inst,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic                  d_req_wen,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_resp_valid,
  output logic [DATA_WIDTH-1:0] d_resp_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_wen,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [ADDR_WIDTH-1:0] mem_resp_addr,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic [31:0]           perf_i_grants,
  output logic [31:0]           perf_d_grants,
  output logic [31:0]           perf_stall_cycles
);
  arb_state_t state;
  owner_t owner;
  mem_req_t win;
  logic resp, issue, any_req, xfer, i_fire, d_fire;
  assign resp = reset_n && mem_resp_valid && state != IDLE;
  assign issue = (reset_n && state == IDLE) || resp;
  assign any_req = i_req_valid || d_req_valid;
  assign mem_req_valid = issue && any_req;
  assign xfer = mem_req_valid && mem_req_ready;
  assign i_fire = xfer && owner == OWN_I;
  assign d_fire = xfer && owner == OWN_D;
  assign i_req_ready = issue && mem_req_ready && owner == OWN_I;
  assign d_req_ready = issue && mem_req_ready && owner == OWN_D;

  arb_starve_picker #(.STARVE_LIMIT(STARVE_LIMIT)) u_picker (
    .clk(clk), .reset_n(reset_n), .i_valid(i_req_valid), .d_valid(d_req_valid),
    .issue(issue), .i_fire(i_fire), .d_fire(d_fire), .owner(owner)
  );

  // fetches never write, so the fetch side drives a clean read
  always_comb
    win = owner == OWN_I ? mem_req_t'{addr: MEMARB_AW'(i_req_addr), wen: 1'b0, wdata: '0}
                         : mem_req_t'{addr: MEMARB_AW'(d_req_addr), wen: d_req_wen, wdata: MEMARB_DW'(d_req_wdata)};
  assign mem_req_addr = ADDR_WIDTH'(win.addr);
  assign mem_req_wen = win.wen;
  assign mem_req_wdata = DATA_WIDTH'(win.wdata);

  assign i_resp_valid = resp && state == WAIT_I && !i_kill;
  assign i_resp_addr = mem_resp_addr;
  assign i_resp_inst = mem_resp_data;
  assign d_resp_valid = resp && state == WAIT_D;
  assign d_resp_rdata = mem_resp_data;

  // one outstanding transaction: a transfer opens a wait, a response with no follow-on transfer closes it
  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else if (xfer) state <= owner == OWN_I ? WAIT_I : WAIT_D;
    else if (resp) state <= IDLE;
    else if (state == WAIT_I && i_kill) state <= WAIT_DROP;

`ifdef MEMARB_PERF_EN
  // grant and stall event counters, wrapping naturally
  always_ff @(posedge clk)
    if (!reset_n) begin
      perf_i_grants <= '0;
      perf_d_grants <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_i_grants <= perf_i_grants + 32'(i_fire);
      perf_d_grants <= perf_d_grants + 32'(d_fire);
      perf_stall_cycles <= perf_stall_cycles + 32'(any_req && !xfer);
    end
`else
  assign perf_i_grants = '0;
  assign perf_d_grants = '0;
  assign perf_stall_cycles = '0;
`endif

`ifndef SYNTHESIS
  // a response with nothing outstanding means the memory side is misbehaving
  always_ff @(posedge clk)
    if (reset_n && state == IDLE && mem_resp_valid) $error("mem_port_arbiter: response with no outstanding request");
`endif
endmodule
